// File: rtl/sbox_prog.sv
// Programmable multi-lane byte substitution with valid/ready streaming.
// A forward table and its write-maintained inverse feed a single output register.
module sbox_prog #(
  parameter int unsigned DATAW = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  input  logic             tbl_we,
  input  logic [7:0]       tbl_addr,
  input  logic [7:0]       tbl_wdata,
  output logic [CNTW-1:0]  xfer_cnt
);

  localparam int unsigned LANES = DATAW / 8;

  logic [7:0]       r_fwd [256];
  logic [7:0]       r_inv [256];
  logic             r_out_valid;
  logic [DATAW-1:0] r_out_data;
  logic [CNTW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_xfer;
  logic [DATAW-1:0] w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign xfer_cnt  = r_cnt;

  // Reads the registered tables, so a same-cycle write is not yet visible.
  always_comb begin
    w_result = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_result[8*k +: 8] = in_inv ? r_inv[in_data[8*k +: 8]]
                                  : r_fwd[in_data[8*k +: 8]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 256; i++) begin
        r_fwd[8'(i)] <= 8'(i);
        r_inv[8'(i)] <= 8'(i);
      end
    end else if (tbl_we) begin
      r_fwd[tbl_addr]  <= tbl_wdata;
      r_inv[tbl_wdata] <= tbl_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

endmodule

// File: doc/sbox_prog.md
# sbox_prog

Programmable, multi-lane byte-substitution stage with a valid/ready stream interface. Each 8-bit lane of an input word is replaced through a 256-entry forward table, or through its automatically maintained inverse, in one registered cycle at full throughput. The forward table is writable at runtime, so cipher datapaths can load key-dependent or alternate S-boxes without resynthesis. The block replaces fixed combinational substitution where backpressure and runtime table loading are required.

## Interface
- DATAW, 16: data width in bits; multiple of 8, ≥ 8. LANES = DATAW/8.
- CNTW, 16: width of the completed-transfer counter.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept an input word
- in_data  in  DATAW  input word; lane k = bits [8k+7:8k]
- in_inv  in  1  0 = forward lookup, 1 = inverse lookup; sampled with in_data
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_data  out  DATAW  substituted word
- tbl_we  in  1  table write strobe
- tbl_addr  in  8  forward-table index to write
- tbl_wdata  in  8  value to store at tbl_addr
- xfer_cnt  out  CNTW  count of completed output transfers

## Operation
- Storage: FWD[0..255] and INV[0..255], 8 bits each, flops. Reset sets both to identity (FWD[i] = INV[i] = i).
- Table write: on a clock edge with tbl_we=1: FWD[tbl_addr] ← tbl_wdata and INV[tbl_wdata] ← tbl_addr. No other entries change. Writes are accepted every cycle and never stall.
- INV is the true inverse only while FWD is a permutation. Software loads a full permutation before issuing inverse lookups. Inverse results after a partial or non-bijective load are defined only by the write rule above; the bench checks them against that rule.
- Lookup: an input is accepted on a cycle with in_valid && in_ready. Lane k of the result is FWD[in_data lane k] when in_inv=0, or INV[in_data lane k] when in_inv=1. All lanes share the same tables and the same in_inv.
- Write/lookup collision: a lookup accepted in the same cycle as a write uses the pre-write tables. Lookups accepted in later cycles see the new entry.
- Output stage: a single register holds out_data and out_valid.
  - in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid to in_ready).
  - On accept, the register loads the result and out_valid ← 1.
  - On out_valid && out_ready with no new accept, out_valid ← 0. out_data holds its last value.
  - While out_valid=1 and out_ready=0, out_data and out_valid are stable.
- Counter: xfer_cnt increments by 1 on every cycle with out_valid && out_ready. It wraps modulo 2^CNTW with no saturation.
- Reset mid-operation: any pending output word is discarded. Tables revert to identity.

## Timing
- Reset values: in_ready=1 (follows from out_valid=0), out_valid=0, out_data=0, xfer_cnt=0, tables identity.
- Latency: 1 cycle. A word accepted at edge N is presented on out_data/out_valid after edge N.
- Throughput: 1 word/cycle while out_ready=1. Accept and output transfer may occur in the same cycle (pass-through replace).
- Table write effect: visible to lookups accepted from the cycle after the write edge.
- Back-to-back writes to the same tbl_addr: the last write wins in FWD. Stale INV entries from earlier values remain.

## Test plan
- Reset identity: after reset, stream in_data=16'h3CA5 with in_inv=0, then in_inv=1, out_ready=1 → outputs 16'h3CA5 twice; latency 1; xfer_cnt=2.
- Load and forward: write FWD[8'hA5]=8'h17 and FWD[8'h3C]=8'hE0, then look up 16'h3CA5 forward → 16'hE017. Look up 16'hE017 with in_inv=1 → 16'h3CA5.
- Collision: in the same cycle, write FWD[8'h01]=8'h80 and accept 16'h0101 forward → 16'h0101. The next accepted 16'h0101 → 16'h8080.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → one word captured, in_ready=0, out_data stable. Release → one transfer per cycle, no loss or duplication, order preserved, xfer_cnt matches.
- Full permutation: load FWD[i]=(i*7+3) mod 256, then stream all 256 values forward and inverse with random out_ready → forward matches formula; inverse of forward output returns i.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 → out_valid=0, xfer_cnt=0 immediately. After release, a lookup of 8'h55 forward returns 8'h55 (tables back to identity).
